serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: computes DIFF = A - B, LSB first, one bit per clock.
//   Companion to the combinational half/full adder blocks. Gives the datapath a subtract
//   path that uses a single full-subtractor cell plus shift registers.
//   START/DONE handshake; sits between the operand registers and the result bus.
// PARAMETERS
//   WIDTH   4   operand/result width in bits; legal range 1..32
// PORTS
//   CLK     in   1      rising-edge clock; the only clock
//   RST     in   1      asynchronous reset, active-low
//   START   in   1      request; sampled only in IDLE or DONE state
//   A       in   WIDTH  minuend; captured on an accepted START
//   B       in   WIDTH  subtrahend; captured on an accepted START
//   BUSY    out  1      high while in SHIFT state
//   DONE    out  1      one-cycle pulse; DIFF/BORROW valid from this cycle
//   DIFF    out  WIDTH  (A - B) mod 2^WIDTH
//   BORROW  out  1      1 if A < B (unsigned), i.e. final borrow-out
// BEHAVIOUR
//   Reset (RST=0, async): state=IDLE; BUSY=0, DONE=0, DIFF=0, BORROW=0; shift regs, count, borrow flop =0.
//   States: IDLE -> SHIFT on START; SHIFT -> DONE when count==WIDTH-1; DONE -> SHIFT if START else IDLE.
//   Accept (IDLE or DONE with START=1): a_sr<=A, b_sr<=B, borrow<=0, count<=0, res_sr<=0.
//   SHIFT, each cycle: a=a_sr[0], b=b_sr[0], bin=borrow flop.
//     d=a^b^bin; bout=(~a&b)|(~(a^b)&bin).
//     res_sr<={d,res_sr[WIDTH-1:1]}; a_sr,b_sr shift right; borrow<=bout; count<=count+1.
//   Entering DONE: DIFF<=final res_sr value (incl. last bit), BORROW<=last bout; DONE=1 for exactly one cycle.
//   Latency: START accepted at edge k -> DONE high in the cycle after edge k+WIDTH; throughput WIDTH+1 cycles/op.
//   Back-to-back: START high during the DONE cycle is accepted; DONE pulses then repeat every WIDTH+1 cycles.
//   START while BUSY: ignored. No queuing. A/B changes while BUSY: no effect.
//   DIFF/BORROW hold the last result until the next DONE; they are not cleared on START.
//   WIDTH=1: SHIFT lasts one cycle; count width = max(1,$clog2(WIDTH)).
//   count wrap: never reaches WIDTH; compare is against WIDTH-1 only.
//   Reset asserted mid-operation: immediate abort, all outputs to reset values; no DONE pulse.
//   BUSY and DONE are never high in the same cycle. BUSY is registered (state decode of registered state).
// STRUCTURE
//   Shared package/include (sub_defs): state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
//     default WIDTH constant. Shared by this block and its bench.
//   Sub-module: full_subtractor (a, b, bin -> d, bout), purely combinational, one instance.
//   Top: FSM, a_sr/b_sr/res_sr shift registers, borrow flop, bit counter, output registers.
// TESTING
//   Bench: WIDTH=4; expected {BORROW,DIFF} computed as A-B in WIDTH+1 bits; compare on DONE; $stop on mismatch.
//   1. A=9,B=3, START 1 cycle -> DONE 5 cycles later; DIFF=6, BORROW=0; BUSY high 4 cycles.
//   2. A=3,B=9 -> DIFF=A (4'hA), BORROW=1.
//   3. A=F,B=F -> DIFF=0, BORROW=0; then A=0,B=1 -> DIFF=F, BORROW=1.
//   4. START held high continuously, A=5,B=2 -> DONE every 5 cycles, DIFF=3 each time;
//      START pulse (A=1,B=1) mid-SHIFT ignored; result still 3.
//   5. RST low in 3rd SHIFT cycle -> BUSY=0, DONE=0, DIFF=0, BORROW=0 immediately; no DONE; next op OK.
//   6. 20 random A/B pairs ($random), back-to-back via DONE-cycle START -> every DONE matches expected.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B, LSB first, one bit per clock, START/DONE handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q;
  logic [WIDTH-1:0] res_sr_d;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;
  logic             d_bit, bout_bit;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // New difference bit enters at the MSB; a one-bit result has nothing to shift down.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_sr_d = d_bit;
    end else begin : g_res_wn
      assign res_sr_d = {d_bit, res_sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_sr_q     <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (START) begin
            state_q  <= S_SHIFT;
            busy_q   <= 1'b1;
            a_sr_q   <= A;
            b_sr_q   <= B;
            res_sr_q <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_sr_d;
          borrow_q <= bout_bit;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            diff_q       <= res_sr_d;
            borrow_out_q <= bout_bit;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DIFF   = diff_q;
  assign BORROW = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, back-to-back, reset abort and random ops.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int LAT = W + 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE, BORROW;
  logic [W-1:0] DIFF;

  int n_checks = 0;
  int n_fail = 0;
  int overlap = 0;
  logic [W-1:0] prev_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF), .BORROW(BORROW)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (BUSY && DONE) overlap++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    r = int'(a) - int'(b);
    if (r < 0) r += (1 << W);
    return {(a < b), r[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic br);
    int cyc;
    int busy_cnt;
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    check("busy_first_cycle", BUSY, 1);
    check("diff_hold_on_start", DIFF, prev_diff);
    busy_cnt = BUSY ? 1 : 0;
    while (!DONE && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (BUSY) busy_cnt++;
    end
    if (!DONE) begin
      check("done_timeout", 0, 1);
      d = 'x; br = 1'bx;
    end else begin
      check("latency", cyc, LAT);
      check("busy_cycles", busy_cnt, W);
      d = DIFF; br = BORROW;
      prev_diff = DIFF;
    end
    @(negedge CLK);
    check("done_one_cycle", DONE, 0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         br;
    logic [W:0]   exp;
    logic [W:0]   q[$];
    int           cyc, last_done, waitc;

    vecs[0] = '{a: 4'h9, b: 4'h3, diff: 4'h6, borrow: 1'b0};
    vecs[1] = '{a: 4'h3, b: 4'h9, diff: 4'hA, borrow: 1'b1};
    vecs[2] = '{a: 4'hF, b: 4'hF, diff: 4'h0, borrow: 1'b0};
    vecs[3] = '{a: 4'h0, b: 4'h1, diff: 4'hF, borrow: 1'b1};
    vecs[4] = '{a: 4'h0, b: 4'h0, diff: 4'h0, borrow: 1'b0};
    vecs[5] = '{a: 4'hF, b: 4'h0, diff: 4'hF, borrow: 1'b0};
    vecs[6] = '{a: 4'h8, b: 4'h7, diff: 4'h1, borrow: 1'b0};
    vecs[7] = '{a: 4'h7, b: 4'h8, diff: 4'hF, borrow: 1'b1};

    // Reset state
    #12;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_diff", DIFF, 0);
    check("rst_borrow", BORROW, 0);
    @(negedge CLK);
    RST = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, d, br);
      check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
      check($sformatf("vec%0d_borrow", i), br, vecs[i].borrow);
      exp = ref_sub(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_model", i), {br, d}, exp);
    end

    // START held high: DONE every W+1 cycles, mid-SHIFT operand change ignored
    @(negedge CLK);
    A = 4'h5; B = 4'h2; START = 1'b1;
    waitc = 0;
    while (!DONE && waitc < 20) begin @(negedge CLK); waitc++; end
    check("hold_first_done", DONE, 1);
    check("hold_first_diff", DIFF, 4'h3);
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(negedge CLK);
      if (i == 2) begin A = 4'h1; B = 4'h1; end
      if (i == 3) begin A = 4'h5; B = 4'h2; end
      check($sformatf("hold_done_c%0d", i), DONE, (i % LAT) == 0);
      if ((i % LAT) == 0) check($sformatf("hold_diff_c%0d", i), DIFF, 4'h3);
    end
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("hold_idle_after", BUSY, 0);
    prev_diff = 4'h3;

    // Reset asserted during the third SHIFT cycle
    A = 4'hC; B = 4'h4; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_busy_before", BUSY, 1);
    RST = 1'b0;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_diff", DIFF, 0);
    check("abort_borrow", BORROW, 0);
    @(negedge CLK);
    RST = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
        @(negedge CLK);
        if (DONE || BUSY) seen++;
      end
      check("abort_no_activity", seen, 0);
    end
    prev_diff = '0;
    run_op(4'hC, 4'h4, d, br);
    check("after_abort_op", {br, d}, ref_sub(4'hC, 4'h4));

    // Random back-to-back operations, next START issued in each DONE cycle
    @(negedge CLK);
    A = W'($urandom); B = W'($urandom); START = 1'b1;
    q.push_back(ref_sub(A, B));
    cyc = 0;
    last_done = -1;
    for (int n = 0; n < 20; n++) begin
      waitc = 0;
      @(negedge CLK); cyc++;
      START = 1'b0;
      while (!DONE && waitc < 20) begin @(negedge CLK); cyc++; waitc++; end
      if (!DONE) begin
        check("rand_timeout", 0, 1);
        break;
      end
      exp = q.pop_front();
      check($sformatf("rand%0d", n), {BORROW, DIFF}, exp);
      if (last_done >= 0) check($sformatf("rand%0d_interval", n), cyc - last_done, LAT);
      last_done = cyc;
      if (n < 19) begin
        A = W'($urandom); B = W'($urandom); START = 1'b1;
        q.push_back(ref_sub(A, B));
      end
    end
    START = 1'b0;
    repeat (3) @(negedge CLK);

    check("busy_done_exclusive", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
